// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down event counter with load, clear and wrap/saturate policy.
// Latency: count/overflow/underflow update on the edge that samples an inc/dec rising edge.
// Backpressure: none; every detected event is consumed in the cycle it is seen.
//
// Ports:
//   clk, reset         - clock (rising edge) and synchronous active-high reset
//   inc, dec           - level inputs; each 0->1 transition is one up/down event
//   clear, load        - synchronous clear to 0 / parallel load (clear wins)
//   load_value         - BCD value to load, digit i at [4i+3:4i]; digits > 9 load as 9
//   count              - current BCD count, digit 0 least significant
//   overflow/underflow - one-cycle pulses on an up-step from all-9s / down-step from 0
module bcd_updown_counter #(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int W = 4 * DIGITS;

    logic         inc_prev;
    logic         dec_prev;
    logic         up_evt;
    logic         dn_evt;
    logic [W-1:0] count_inc;
    logic [W-1:0] count_dec;
    logic [W-1:0] load_clamped;
    logic         all_nine;
    logic         all_zero;

    assign up_evt = inc & ~inc_prev;
    assign dn_evt = dec & ~dec_prev;

    // Ripple carry/borrow through the digits. The carry (borrow) that falls
    // out of the top digit means the count was all 9s (all 0s); in that case
    // the rippled value is already the wrapped result (0 or all 9s).
    always_comb begin
        logic       carry;
        logic       borrow;
        logic [3:0] d;
        carry        = 1'b1;
        borrow       = 1'b1;
        count_inc    = '0;
        count_dec    = '0;
        load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = count[4*i +: 4];
            if (carry) begin
                if (d == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = d + 4'd1;
                    carry               = 1'b0;
                end
            end else begin
                count_inc[4*i +: 4] = d;
            end

            if (borrow) begin
                if (d == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = d - 4'd1;
                    borrow              = 1'b0;
                end
            end else begin
                count_dec[4*i +: 4] = d;
            end

            load_clamped[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd9
                                                                   : load_value[4*i +: 4];
        end
        all_nine = carry;
        all_zero = borrow;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inc_prev  <= 1'b0;
            dec_prev  <= 1'b0;
        end else begin
            // Edge history keeps tracking through clear/load so a level held
            // across them never produces a late event.
            inc_prev  <= inc;
            dec_prev  <= dec;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            if (clear) begin
                count <= '0;
            end else if (load) begin
                count <= load_clamped;
            end else if (up_evt && !dn_evt) begin
                if (all_nine) begin
                    overflow <= 1'b1;
                end
                if (!(SATURATE && all_nine)) begin
                    count <= count_inc;
                end
            end else if (dn_evt && !up_evt) begin
                if (all_zero) begin
                    underflow <= 1'b1;
                end
                if (!(SATURATE && all_zero)) begin
                    count <= count_dec;
                end
            end
        end
    end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised multi-digit BCD up/down event counter; the generalised successor of the team's 2-digit edge-triggered decimal counter.
- Counts rising edges of two independent level inputs, `inc` and `dec`.
- Supports parallel load, synchronous clear, and a selectable wrap or saturate policy.
- Flags overflow and underflow with single-cycle pulses.
- Drives 7-segment display digits and event tallies in the NPC peripheral area.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); count width is 4*DIGITS.
- SATURATE, 0, overflow/underflow policy. 0 = wrap (max+1 → 0, 0−1 → max). 1 = hold at limit.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- inc  input  1  level; each 0→1 transition is one up-event.
- dec  input  1  level; each 0→1 transition is one down-event.
- clear  input  1  synchronous clear of count to 0.
- load  input  1  synchronous parallel load.
- load_value  input  4*DIGITS  BCD value to load. Digit i is at bits [4i+3:4i].
- count  output  4*DIGITS  current BCD count. Digit 0 is least significant.
- overflow  output  1  one-cycle pulse on an up-step from the max value (all digits 9).
- underflow  output  1  one-cycle pulse on a down-step from 0.

Behaviour:
- Clock is clk. Reset is reset, synchronous, active-high.
- Reset values: count = 0, overflow = 0, underflow = 0, inc_prev = 0, dec_prev = 0.
- Edge detection:
  - inc_prev and dec_prev are registered copies of inc and dec, updated every non-reset cycle including clear and load cycles.
  - up_evt = inc & ~inc_prev; dn_evt = dec & ~dec_prev.
  - Level held high produces exactly one event.
  - If inc is high on the first cycle after reset release, that counts as an edge (inc_prev reset to 0).
- Priority per cycle, highest first:
  1. reset
  2. clear
  3. load
  4. step
  5. hold
- Clear: count ← 0. Any coincident events are discarded. No flag pulses.
- Load: count ← load_value, with any digit > 9 replaced by 9. Coincident events are discarded. No flag pulses.
- Step resolution:
  - up_evt & ~dn_evt → increment.
  - dn_evt & ~up_evt → decrement.
  - Both events in the same cycle cancel: count holds, no flags.
- Increment (ripple BCD):
  - Digit 0 + 1.
  - A digit at 9 becomes 0 and carries into the next digit; a carry stops at the first digit < 9.
  - If all digits are 9:
    - SATURATE=0: count → 0, overflow = 1.
    - SATURATE=1: count holds, overflow = 1.
- Decrement (ripple BCD borrow):
  - A digit at 0 becomes 9 and borrows from the next digit.
  - If count == 0:
    - SATURATE=0: count → all 9s, underflow = 1.
    - SATURATE=1: count holds 0, underflow = 1.
- Latency:
  - count, overflow and underflow update on the same clock edge that samples the event, and are visible one cycle after inc/dec rises.
  - overflow and underflow are high for exactly that one cycle and 0 otherwise.
- Invariant: every digit of count is always in 0..9.
- Reset mid-sequence: edge history is lost. A level still high after reset counts once (see edge detection).

Test Plan:
- Reset, then pulse inc 12 times (1 cycle high, 1 cycle low) → count = 0x0012, no flags. Hold inc high 5 cycles → exactly one increment, count = 0x0013.
- Load 0x0999, then one inc edge → count = 0x1000 (3-digit carry ripple). One dec edge → 0x0999. Load 0x0A9F → count = 0x0999.
- DIGITS=4, SATURATE=0: load 0x9999, inc edge → count = 0x0000 and overflow high for 1 cycle. dec edge → count = 0x9999 and underflow high for 1 cycle.
- SATURATE=1: load 0x9999, inc edge → count stays 0x9999, overflow pulses. Clear, then dec edge → count stays 0, underflow pulses.
- Same-cycle events:
  - inc and dec rise together at count 0x0050 → count stays 0x0050, no flags.
  - inc edge coincident with load 0x0007 → count = 0x0007; the next cycle with inc still high does not increment.
  - clear together with load → count = 0.
- Assert reset while inc is held high, then release → count = 0x0001 one cycle after release.
- Randomised inc/dec edges checked against a decimal reference model modulo 10^DIGITS, with the BCD-digit-legal invariant checked every cycle.
